// File: rtl/race_tap_mac_if.sv
// rtl/race_tap_mac_if.sv - tap-mux side bus of the RACE serial MAC
interface race_tap_mac_if #(
   parameter int SIZE = 16
);
   logic            start;
   logic [3:0]      sel;
   logic [SIZE-1:0] x_in;
   logic [SIZE-1:0] coef_in;
   logic            busy;
   logic [SIZE-1:0] y_out;
   logic            y_valid;

   modport slave (
      input  start, x_in, coef_in,
      output sel, busy, y_out, y_valid
   );

   modport master (
      output start, x_in, coef_in,
      input  sel, busy, y_out, y_valid
   );
endinterface

// File: rtl/race_tap_mac.sv
// rtl/race_tap_mac.sv - serial multiply-accumulate over TAPS muxed taps, rounded and saturated
module race_tap_mac #(
   parameter int SIZE  = 16,
   parameter int TAPS  = 15,
   parameter int FRAC  = 15,
   parameter int ACC_W = 2*SIZE+4
) (
   input logic         clk,
   input logic         rst,
   race_tap_mac_if.slave bus
);
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_FLUSH = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [3:0] LAST = 4'(TAPS-1);
   localparam logic signed [ACC_W-1:0] RND   = ACC_W'(1) << (FRAC-1);
   localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'((2**(SIZE-1))-1);
   localparam logic signed [ACC_W-1:0] MIN_V = -MAX_V - ACC_W'(1);

   logic [1:0]                state;
   logic [3:0]                cnt;
   logic signed [ACC_W-1:0]   acc;
   logic signed [2*SIZE-1:0]  prod_r;
   logic                      p_valid;
   logic [SIZE-1:0]           y_r;
   logic                      y_valid_r;

   logic signed [ACC_W-1:0]   prod_ext;
   logic signed [ACC_W-1:0]   acc_sh;
   logic [SIZE-1:0]           y_sat;

   assign prod_ext = $signed({{(ACC_W-2*SIZE){prod_r[2*SIZE-1]}}, prod_r});
   assign acc_sh   = (acc + RND) >>> FRAC;

   always_comb begin
      y_sat = acc_sh[SIZE-1:0];
      if (acc_sh > MAX_V)
         y_sat = {1'b0, {(SIZE-1){1'b1}}};
      else if (acc_sh < MIN_V)
         y_sat = {1'b1, {(SIZE-1){1'b0}}};
   end

   // Outside RUN the select parks on tap 0 so the muxes never see an out-of-range index.
   assign bus.sel     = (state == S_RUN) ? cnt : 4'd0;
   assign bus.busy    = (state != S_IDLE);
   assign bus.y_out   = y_r;
   assign bus.y_valid = y_valid_r;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= 4'd0;
         acc       <= '0;
         prod_r    <= '0;
         p_valid   <= 1'b0;
         y_r       <= '0;
         y_valid_r <= 1'b0;
      end else begin
         y_valid_r <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  state   <= S_RUN;
                  cnt     <= 4'd0;
                  acc     <= '0;
                  p_valid <= 1'b0;
               end
            end
            S_RUN: begin
               // Product is registered, so accumulation trails the select by one tap.
               prod_r  <= $signed(bus.x_in) * $signed(bus.coef_in);
               p_valid <= 1'b1;
               if (p_valid)
                  acc <= acc + prod_ext;
               cnt <= cnt + 4'd1;
               if (cnt == LAST)
                  state <= S_FLUSH;
            end
            S_FLUSH: begin
               acc   <= acc + prod_ext;
               state <= S_DONE;
            end
            S_DONE: begin
               y_r       <= y_sat;
               y_valid_r <= 1'b1;
               state     <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule
